// File: rtl/iic_slave_mem.sv
`timescale 1ns/1ps
// iic_slave_mem
// IIC slave exposing a byte memory behind a 16-bit auto-incrementing
// address pointer. Writes: DEV(W), ADDR_HI, ADDR_LO, data...
// Reads: DEV(R), data... from the current pointer (random read by writing
// the address, then issuing a repeated START with DEV(R)).
module iic_slave_mem #(
  parameter logic [6:0]  DEV_ADDR = 7'b1010011,
  parameter int unsigned MEM_AW   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl,
  inout  wire         sda,
  output logic        wr_pulse,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy
);

  localparam int unsigned DEPTH = 2 ** MEM_AW;

  typedef enum logic [3:0] {
    IDLE,
    DEV,
    ACK_DEV,
    AH,
    ACK_AH,
    AL,
    ACK_AL,
    WR,
    ACK_WR,
    RD,
    RACK,
    WAIT_STOP
  } state_e;

  // Bus synchronizers and edge history
  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_s;
  logic       sda_s;
  logic       scl_d;
  logic       sda_d;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;

  // FSM and datapath state
  state_e      state_q,    state_d;
  logic [3:0]  bit_cnt_q,  bit_cnt_d;
  logic [7:0]  shift_q,    shift_d;
  logic        sda_oe_q,   sda_oe_d;
  logic [15:0] ptr_q,      ptr_d;
  logic        rw_q,       rw_d;
  logic        busy_q,     busy_d;
  logic        wr_pulse_q, wr_pulse_d;
  logic [15:0] wr_addr_q,  wr_addr_d;
  logic [7:0]  wr_data_q,  wr_data_d;
  logic        mem_we;

  logic [7:0] mem [DEPTH];
  logic [7:0] mem_rd;
  logic [7:0] rx_byte;

  // Open-drain pad: only ever pull low or let go.
  assign sda = sda_oe_q ? 1'b0 : 1'bz;

  assign scl_s = scl_sync[1];
  assign sda_s = sda_sync[1];

  // scl and sda share the same synchronizer latency, so their relative
  // ordering is preserved and START/STOP can be seen as sda edges while
  // the synchronized scl is stable high.
  assign scl_rise  =  scl_s & ~scl_d;
  assign scl_fall  = ~scl_s &  scl_d;
  assign start_det =  scl_s &  scl_d &  sda_d & ~sda_s;
  assign stop_det  =  scl_s &  scl_d & ~sda_d &  sda_s;

  assign rx_byte = {shift_q[6:0], sda_s};
  assign mem_rd  = mem[ptr_q[MEM_AW-1:0]];

  assign wr_pulse = wr_pulse_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;

  // Synchronize the bus lines; idle bus reads as high.
  // NOTE: sequential blocks use non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, like real hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  // Next-state and datapath decisions, driven by the bus edge strobes.
  // NOTE: every signal gets a default at the top so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    sda_oe_d   = sda_oe_q;
    ptr_d      = ptr_q;
    rw_d       = rw_q;
    busy_d     = busy_q;
    wr_pulse_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    mem_we     = 1'b0;

    if (stop_det) begin
      state_d   = IDLE;
      sda_oe_d  = 1'b0;
      bit_cnt_d = '0;
    end else if (start_det) begin
      // Repeated START lands here too; a partial WR byte is simply dropped.
      state_d   = DEV;
      sda_oe_d  = 1'b0;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        DEV, AH, AL, WR: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              if (state_q == DEV) begin
                if (rx_byte[7:1] == DEV_ADDR) begin
                  state_d = ACK_DEV;
                  rw_d    = rx_byte[0];
                end else begin
                  state_d = WAIT_STOP;
                end
              end else if (state_q == AH) begin
                ptr_d[15:8] = rx_byte;
                state_d     = ACK_AH;
              end else if (state_q == AL) begin
                ptr_d[7:0] = rx_byte;
                state_d    = ACK_AL;
              end else begin
                mem_we     = 1'b1;
                wr_pulse_d = 1'b1;
                wr_addr_d  = ptr_q;
                wr_data_d  = rx_byte;
                ptr_d      = ptr_q + 16'd1;
                state_d    = ACK_WR;
              end
            end
          end
        end

        ACK_DEV, ACK_AH, ACK_AL, ACK_WR: begin
          // First scl fall after bit 8 pulls sda low; the next fall ends
          // the ACK slot and moves on.
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              if (state_q == ACK_DEV && rw_q) begin
                // The ACK-release fall is also the first data-out edge.
                state_d  = RD;
                shift_d  = mem_rd;
                sda_oe_d = ~mem_rd[7];
              end else if (state_q == ACK_DEV) begin
                state_d = AH;
              end else if (state_q == ACK_AH) begin
                state_d = AL;
              end else begin
                state_d = WR;
              end
            end
          end
        end

        RD: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd0) begin
              sda_oe_d = ~shift_q[7];
            end else if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b0;
              ptr_d     = ptr_q + 16'd1;
              bit_cnt_d = '0;
              state_d   = RACK;
            end else begin
              sda_oe_d = ~shift_q[6];
              shift_d  = {shift_q[6:0], 1'b0};
            end
          end
        end

        RACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              shift_d   = mem_rd;
              bit_cnt_d = '0;
              state_d   = RD;
            end else begin
              state_d = WAIT_STOP;
            end
          end
        end

        default: ;
      endcase
    end

    if (state_d == ACK_DEV) begin
      busy_d = 1'b1;
    end else if (state_d == IDLE || state_d == WAIT_STOP) begin
      busy_d = 1'b0;
    end
  end

  // State and datapath registers; reset aborts any transaction at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      sda_oe_q   <= 1'b0;
      ptr_q      <= '0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      wr_pulse_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      sda_oe_q   <= sda_oe_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
      wr_pulse_q <= wr_pulse_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Byte memory write port.
  // NOTE: the array has no reset: contents must survive rst_n, and a reset
  // loop over an array would also prevent RAM inference.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[ptr_q[MEM_AW-1:0]] <= rx_byte;
    end
  end

endmodule

// File: tb/tb_iic_slave_mem.sv
`timescale 1ns/1ps
// tb_iic_slave_mem
// Bit-banged IIC master driving iic_slave_mem, checked against a
// transaction-level model: a byte array plus a pointer and an expected
// write-event queue.
module tb_iic_slave_mem;

  localparam int         Q      = 6;  // clk cycles per quarter scl period
  localparam logic [6:0] DEV    = 7'b1010011;
  localparam logic [7:0] ADDR_W = {DEV, 1'b0};
  localparam logic [7:0] ADDR_R = {DEV, 1'b1};

  typedef logic [7:0] byte_q_t[$];

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b1;
  logic        scl     = 1'b1;
  logic        sda_drv = 1'b1;
  wire         sda;
  logic        wr_pulse;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [7:0]  mdl_mem [256];
  logic [15:0] mdl_ptr = 16'h0000;
  logic [23:0] exp_q[$];
  logic [23:0] obs_q[$];

  assign sda = sda_drv ? 1'bz : 1'b0;
  pullup (sda);

  iic_slave_mem #(.DEV_ADDR(DEV), .MEM_AW(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl      (scl),
    .sda      (sda),
    .wr_pulse (wr_pulse),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (wr_pulse === 1'b1) obs_q.push_back({wr_addr, wr_data});
  end

  initial begin
    #(95000 * 20);
    $display("FAIL watchdog: simulation exceeded its cycle budget");
    $fatal(1, "watchdog");
  end

  // ---------------- model ----------------
  function automatic void mdl_write(input logic [7:0] b);
    mdl_mem[mdl_ptr[7:0]] = b;
    exp_q.push_back({mdl_ptr, b});
    mdl_ptr = mdl_ptr + 16'd1;
  endfunction

  function automatic logic [7:0] mdl_read();
    logic [7:0] b;
    b = mdl_mem[mdl_ptr[7:0]];
    mdl_ptr = mdl_ptr + 16'd1;
    return b;
  endfunction

  // ---------------- bus master ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    tick(Q); sda_drv = 1'b1;
    tick(Q); scl = 1'b1;
    tick(Q); sda_drv = 1'b0;
    tick(Q); scl = 1'b0;
  endtask

  task automatic bus_stop();
    tick(Q); sda_drv = 1'b0;
    tick(Q); scl = 1'b1;
    tick(Q); sda_drv = 1'b1;
    tick(Q);
  endtask

  task automatic bus_wbit(input logic b);
    tick(Q); sda_drv = b;
    tick(Q); scl = 1'b1;
    tick(2 * Q); scl = 1'b0;
  endtask

  task automatic bus_rbit(output logic b);
    tick(Q); sda_drv = 1'b1;
    tick(Q); scl = 1'b1;
    tick(Q); b = sda;
    tick(Q); scl = 1'b0;
  endtask

  task automatic bus_wbyte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) bus_wbit(d[i]);
    bus_rbit(b);
    ack = ~b;
  endtask

  task automatic bus_rbyte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      bus_rbit(b);
      d[i] = b;
    end
    bus_wbit(nack);
  endtask

  // Full write transaction; n_nack counts bytes the slave failed to ACK.
  task automatic txn_write(input logic [15:0] addr, input byte_q_t data,
                           output int n_nack);
    logic ack;
    n_nack = 0;
    bus_start();
    bus_wbyte(ADDR_W, ack);      if (!ack) n_nack++;
    bus_wbyte(addr[15:8], ack);  if (!ack) n_nack++;
    bus_wbyte(addr[7:0], ack);   if (!ack) n_nack++;
    foreach (data[i]) begin
      bus_wbyte(data[i], ack);   if (!ack) n_nack++;
    end
    bus_stop();
  endtask

  // Read n bytes; optionally set the pointer first (random read).
  task automatic txn_read(input bit set_addr, input logic [15:0] addr,
                          input int n, output byte_q_t got, output int n_nack);
    logic       ack;
    logic [7:0] d;
    n_nack = 0;
    got = {};
    bus_start();
    if (set_addr) begin
      bus_wbyte(ADDR_W, ack);     if (!ack) n_nack++;
      bus_wbyte(addr[15:8], ack); if (!ack) n_nack++;
      bus_wbyte(addr[7:0], ack);  if (!ack) n_nack++;
      bus_start();
    end
    bus_wbyte(ADDR_R, ack);       if (!ack) n_nack++;
    for (int i = 0; i < n; i++) begin
      bus_rbyte(i == n - 1, d);
      got.push_back(d);
    end
    bus_stop();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    tick(2);
    rst_n = 1'b0;
    tick(5);
    checks++; if (sda !== 1'b1)       begin errors++; $display("FAIL reset_sda got %b want 1", sda); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (wr_pulse !== 1'b0)  begin errors++; $display("FAIL reset_wr_pulse got %b want 0", wr_pulse); end
    checks++; if (wr_addr !== 16'h0)  begin errors++; $display("FAIL reset_wr_addr got %h want 0000", wr_addr); end
    checks++; if (wr_data !== 8'h0)   begin errors++; $display("FAIL reset_wr_data got %h want 00", wr_data); end
    rst_n = 1'b1;
    mdl_ptr = 16'h0000;
    tick(Q);
  endtask

  task automatic test_byte_write();
    logic [3:0] acks;
    logic       a;
    obs_q.delete(); exp_q.delete();
    bus_start();
    bus_wbyte(ADDR_W, a); acks[3] = a;
    bus_wbyte(8'h00, a);  acks[2] = a;
    bus_wbyte(8'h5A, a);  acks[1] = a;
    bus_wbyte(8'h6B, a);  acks[0] = a;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bw_busy_mid got %b want 1", busy); end
    bus_stop();
    mdl_ptr = 16'h005A;
    mdl_write(8'h6B);
    checks++; if (acks !== 4'hF) begin errors++; $display("FAIL bw_acks got %b want 1111", acks); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bw_busy_end got %b want 0", busy); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL bw_npulse got %0d want %0d", obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL bw_event[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random_read();
    logic       a;
    int         n_nack;
    logic [7:0] d;
    logic [7:0] want;
    obs_q.delete();
    n_nack = 0;
    bus_start();
    bus_wbyte(ADDR_W, a); if (!a) n_nack++;
    bus_wbyte(8'h00, a);  if (!a) n_nack++;
    bus_wbyte(8'h5A, a);  if (!a) n_nack++;
    bus_start();
    bus_wbyte(ADDR_R, a); if (!a) n_nack++;
    bus_rbyte(1'b1, d);
    mdl_ptr = 16'h005A;
    want = mdl_read();
    checks++; if (n_nack != 0)   begin errors++; $display("FAIL rr_acks got %0d nacks want 0", n_nack); end
    checks++; if (d !== want)    begin errors++; $display("FAIL rr_data got %h want %h", d, want); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_busy_after_nack got %b want 0", busy); end
    bus_stop();
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL rr_no_write got %0d pulses want 0", obs_q.size()); end
  endtask

  task automatic test_sequential();
    byte_q_t data;
    byte_q_t got;
    int      n_nack;
    logic [7:0] want;
    obs_q.delete(); exp_q.delete();
    txn_write(16'h0064, '{8'hC3}, n_nack);
    mdl_ptr = 16'h0064; mdl_write(8'hC3);
    checks++; if (n_nack != 0) begin errors++; $display("FAIL seq_pre_acks got %0d nacks want 0", n_nack); end
    data = {};
    for (int i = 0; i < 10; i++) data.push_back(8'h6B + 8'(i));
    txn_write(16'h005A, data, n_nack);
    mdl_ptr = 16'h005A;
    foreach (data[i]) mdl_write(data[i]);
    checks++; if (n_nack != 0) begin errors++; $display("FAIL seq_wr_acks got %0d nacks want 0", n_nack); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL seq_npulse got %0d want %0d", obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL seq_event[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    txn_read(1'b1, 16'h005A, 10, got, n_nack);
    mdl_ptr = 16'h005A;
    checks++; if (n_nack != 0) begin errors++; $display("FAIL seq_rd_acks got %0d nacks want 0", n_nack); end
    for (int i = 0; i < 10; i++) begin
      want = mdl_read();
      checks++; if (got[i] !== want) begin errors++; $display("FAIL seq_rd[%0d] got %h want %h", i, got[i], want); end
    end
    // Current-address read shows where the pointer was left.
    txn_read(1'b0, 16'h0000, 1, got, n_nack);
    want = mdl_read();
    checks++; if (got[0] !== want) begin errors++; $display("FAIL seq_ptr_end got %h want %h", got[0], want); end
  endtask

  task automatic test_wrong_addr();
    byte_q_t got;
    int      n_nack;
    int      n_ack;
    logic    a;
    logic [7:0] want;
    txn_write(16'h0030, '{8'h11, 8'h22, 8'h33}, n_nack);
    mdl_ptr = 16'h0030;
    mdl_write(8'h11); mdl_write(8'h22); mdl_write(8'h33);
    txn_read(1'b1, 16'h0030, 1, got, n_nack);
    mdl_ptr = 16'h0030;
    want = mdl_read();
    checks++; if (got[0] !== want) begin errors++; $display("FAIL wa_setup got %h want %h", got[0], want); end
    obs_q.delete();
    n_ack = 0;
    bus_start();
    bus_wbyte(8'hA4, a);
    checks++; if (a !== 1'b0)    begin errors++; $display("FAIL wa_dev_ack got ack=%b want 0", a); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wa_busy got %b want 0", busy); end
    bus_wbyte(8'h00, a); if (a) n_ack++;
    bus_wbyte(8'h30, a); if (a) n_ack++;
    bus_wbyte(8'hEE, a); if (a) n_ack++;
    bus_stop();
    checks++; if (n_ack != 0)        begin errors++; $display("FAIL wa_later_acks got %0d want 0", n_ack); end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL wa_no_write got %0d pulses want 0", obs_q.size()); end
    txn_read(1'b0, 16'h0000, 2, got, n_nack);
    for (int i = 0; i < 2; i++) begin
      want = mdl_read();
      checks++; if (got[i] !== want) begin errors++; $display("FAIL wa_ptr_kept[%0d] got %h want %h", i, got[i], want); end
    end
    txn_read(1'b1, 16'h0030, 1, got, n_nack);
    mdl_ptr = 16'h0030;
    want = mdl_read();
    checks++; if (got[0] !== want) begin errors++; $display("FAIL wa_mem_kept got %h want %h", got[0], want); end
  endtask

  task automatic test_wrap();
    byte_q_t got;
    int      n_nack;
    logic [7:0] d0, d1, want;
    d0 = 8'($urandom);
    d1 = 8'($urandom);
    obs_q.delete(); exp_q.delete();
    txn_write(16'hFFFF, '{d0, d1}, n_nack);
    mdl_ptr = 16'hFFFF;
    mdl_write(d0); mdl_write(d1);
    checks++; if (n_nack != 0) begin errors++; $display("FAIL wrap_acks got %0d nacks want 0", n_nack); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL wrap_npulse got %0d want %0d", obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL wrap_event[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    // 0x00FF and 0x0100 alias memory indices 0xFF and 0x00.
    txn_read(1'b1, 16'h00FF, 2, got, n_nack);
    mdl_ptr = 16'h00FF;
    for (int i = 0; i < 2; i++) begin
      want = mdl_read();
      checks++; if (got[i] !== want) begin errors++; $display("FAIL wrap_idx[%0d] got %h want %h", i, got[i], want); end
    end
    txn_read(1'b1, 16'hFFFF, 2, got, n_nack);
    mdl_ptr = 16'hFFFF;
    for (int i = 0; i < 2; i++) begin
      want = mdl_read();
      checks++; if (got[i] !== want) begin errors++; $display("FAIL wrap_rd[%0d] got %h want %h", i, got[i], want); end
    end
  endtask

  task automatic test_reset_mid();
    byte_q_t got;
    int      n_nack;
    logic    a;
    logic [7:0] d, nd, want;
    d = 8'($urandom);
    obs_q.delete(); exp_q.delete();
    bus_start();
    bus_wbyte(ADDR_W, a);
    bus_wbyte(8'h00, a);
    bus_wbyte(8'h5A, a);
    for (int i = 7; i >= 4; i--) bus_wbit(d[i]);
    tick(Q); sda_drv = d[3];
    tick(Q); scl = 1'b1;
    tick(2);
    rst_n = 1'b0;
    tick(2);
    sda_drv = 1'b1;
    tick(2);
    checks++; if (sda !== 1'b1)      begin errors++; $display("FAIL rm_sda got %b want 1", sda); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rm_busy got %b want 0", busy); end
    checks++; if (wr_pulse !== 1'b0) begin errors++; $display("FAIL rm_pulse got %b want 0", wr_pulse); end
    tick(Q);
    rst_n = 1'b1;
    mdl_ptr = 16'h0000;
    tick(Q);
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL rm_no_write got %0d pulses want 0", obs_q.size()); end
    // Pointer restarts at zero after reset.
    txn_read(1'b0, 16'h0000, 1, got, n_nack);
    want = mdl_read();
    checks++; if (got[0] !== want) begin errors++; $display("FAIL rm_ptr_zero got %h want %h", got[0], want); end
    txn_read(1'b1, 16'h005A, 1, got, n_nack);
    mdl_ptr = 16'h005A;
    want = mdl_read();
    checks++; if (got[0] !== want) begin errors++; $display("FAIL rm_mem_kept got %h want %h", got[0], want); end
    nd = ~d;
    txn_write(16'h005B, '{nd}, n_nack);
    mdl_ptr = 16'h005B; mdl_write(nd);
    checks++; if (n_nack != 0) begin errors++; $display("FAIL rm_after_acks got %0d nacks want 0", n_nack); end
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      errors++; $display("FAIL rm_after_event got %0d pulses first %h want 1 pulse %h",
                         obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 24'h0, exp_q[0]);
    end
  endtask

  task automatic test_random();
    byte_q_t data;
    byte_q_t got;
    int      n_nack;
    int      n;
    logic [15:0] addr;
    logic [7:0]  want;
    for (int it = 0; it < 5; it++) begin
      addr = 16'($urandom);
      n    = int'($urandom_range(1, 4));
      data = {};
      for (int i = 0; i < n; i++) data.push_back(8'($urandom));
      obs_q.delete(); exp_q.delete();
      txn_write(addr, data, n_nack);
      mdl_ptr = addr;
      foreach (data[i]) mdl_write(data[i]);
      checks++; if (n_nack != 0) begin errors++; $display("FAIL rnd%0d_wr_acks got %0d nacks want 0", it, n_nack); end
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        errors++; $display("FAIL rnd%0d_npulse got %0d want %0d", it, obs_q.size(), exp_q.size());
      end else begin
        foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL rnd%0d_event[%0d] got %h want %h", it, i, obs_q[i], exp_q[i]);
        end
      end
      txn_read(1'b1, addr, n, got, n_nack);
      mdl_ptr = addr;
      for (int i = 0; i < n; i++) begin
        want = mdl_read();
        checks++; if (got[i] !== want) begin errors++; $display("FAIL rnd%0d_rd[%0d] got %h want %h", it, i, got[i], want); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_byte_write();
    test_random_read();
    test_sequential();
    test_wrong_addr();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
